cam_frame_writer: RTL
=====================

# cam_frame_writer

Camera-side SDRAM write sequencer in the 133 MHz domain, directly upstream of the bank-switch stage. It drains the camera pixel FIFO in fixed-length bursts into the SDRAM bank currently assigned to the camera (`cam_bank`). It latches that bank at frame start and raises `frame_done`, which drives the bank-switch `cam_rise` input, once the last word of a frame has been handed to the SDRAM controller.

## Interface
- `FRAME_WORDS`, 307200: 16-bit words per frame (640x480); must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 256: words per SDRAM write burst; power of two.
- `ADDR_W`, 22: word-offset width inside one bank.
- `DONE_HOLD`, 4: cycles `frame_done` stays high.
- `clk`  in  1  133 MHz system clock.
- `rst_133`  in  1  asynchronous active-low reset.
- `vsync_sync`  in  1  camera vsync, already synchronised to `clk`; rising edge = frame start.
- `cam_bank`  in  2  bank assigned to the camera by the bank switch.
- `fifo_q`  in  16  show-ahead FIFO data; valid whenever `fifo_empty`=0.
- `fifo_count`  in  10  FIFO read-side fill level.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_rdreq`  out  1  FIFO read acknowledge.
- `fifo_aclr`  out  1  one-cycle FIFO clear at frame start.
- `wr_req`  out  1  burst write request to the SDRAM controller.
- `wr_ack`  in  1  controller accepts the pending burst.
- `wr_bank`  out  2  target bank for the burst.
- `wr_addr`  out  ADDR_W  burst start word offset.
- `wr_data_req`  in  1  controller consumes one word this cycle.
- `wr_data`  out  16  write data (= `fifo_q`).
- `frame_done`  out  1  end-of-frame level, high for `DONE_HOLD` cycles.
- `underrun`  out  1  sticky: data requested while FIFO empty. Cleared at frame start.
- `frame_err`  out  1  one-cycle pulse: frame aborted by early vsync.

## Operation
- States: IDLE, FILL, REQ, BURST, DONE.
- IDLE: wait for a vsync rising edge, detected with a 1-flop delay register. On the edge:
  - latch `cam_bank` into `wr_bank`;
  - zero the word counter and `wr_addr`;
  - pulse `fifo_aclr`;
  - clear `underrun`;
  - go to FILL.
- FILL: when `fifo_count >= BURST_LEN`, go to REQ.
- REQ: `wr_req`=1 until `wr_ack` is sampled high, then go to BURST. `wr_req` drops the cycle after the ack. `wr_addr` and `wr_bank` stay stable throughout REQ.
- BURST: `fifo_rdreq = wr_data_req` (combinational; gaps allowed).
  - Each request increments the burst counter.
  - When the count reaches `BURST_LEN`, `wr_addr += BURST_LEN`.
  - If the frame word count now equals `FRAME_WORDS`, go to DONE; otherwise go to FILL.
- DONE: `frame_done`=1 for `DONE_HOLD` cycles, then IDLE.
- `wr_bank` never changes mid-frame, even though `cam_bank` changes after `frame_done`.
- `wr_data_req` with `fifo_empty`=1: set `underrun`, suppress `fifo_rdreq`, keep counting (the garbage word is accepted).
- Early vsync edge in FILL or IDLE-with-partial-frame: pulse `frame_err` and restart the frame as for a normal frame start. No `frame_done` is raised.
- Early vsync edge in REQ or BURST: remember it and finish the current burst. Then pulse `frame_err` and restart.
- Vsync edge during DONE: finish DONE, then start the new frame immediately, without waiting in IDLE.
- `wr_addr` width must hold `FRAME_WORDS-BURST_LEN`. No wrap inside a frame.

## Timing
- Reset values:
  - state IDLE;
  - `wr_req`, `fifo_rdreq`, `fifo_aclr`, `frame_done`, `underrun`, `frame_err` all 0;
  - `wr_bank`=2'b01, `wr_addr`=0.
- Vsync edge at cycle N: `fifo_aclr` is high at N+1 and `wr_bank` is valid at N+1.
- FILL→REQ happens 1 cycle after the threshold is met.
- `wr_data` has zero latency from `fifo_q`.
- `frame_done` rises 1 cycle after the final `wr_data_req`. The bank switch's 2-flop edge detect then needs ≥2 high cycles, which `DONE_HOLD`≥2 guarantees.
- Reset asserted mid-burst: all outputs return immediately to reset values. The controller is responsible for abandoning the burst.

## Structure
- Shared package holds:
  - the state encoding;
  - the bank codes (2'b00, 2'b01, 2'b10);
  - the `frame_done` polarity constant, shared with the bank switch.
- Single module; no sub-module needed. The vsync edge detector is inline.

## Test plan
- Reset, then one vsync edge with the FIFO fed continuously, `cam_bank`=2'b01 → 1200 bursts with `wr_addr` 0, 256, …, 306944. All have `wr_bank`=1. `frame_done` is high for 4 cycles after the last word.
- `cam_bank` changes from 01 to 10 mid-frame → `wr_bank` stays 01 until the next vsync edge, which latches 10.
- `wr_ack` delayed 20 cycles and `wr_data_req` with random gaps → exactly 256 `fifo_rdreq` per burst, and `wr_req` held stable.
- FIFO empty during a requested word → `underrun`=1 until the next frame start, and `fifo_rdreq` stays 0 for that word.
- Vsync edge after 500 words, mid-burst → the burst completes to word 512, then `frame_err` pulses and the new frame starts at `wr_addr`=0 with no `frame_done`.
- `rst_133` low mid-burst → next cycle: `wr_req`=0, `wr_addr`=0, state IDLE.

Source files
------------

// File: rtl/cam_frame_writer_pkg.sv
// Shared definitions for the camera-side SDRAM write path and its bank switch.
package cam_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_REQ   = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] BANK_0 = 2'b00;
  localparam logic [1:0] BANK_1 = 2'b01;
  localparam logic [1:0] BANK_2 = 2'b10;
  localparam logic [1:0] CAM_RESET_BANK = BANK_1;

  // Level the bank switch treats as "camera frame finished".
  localparam logic FRAME_DONE_ACTIVE = 1'b1;

  // A vsync edge arriving while a burst or the done window is in flight is
  // held until that phase completes instead of acting immediately.
  function automatic logic vsync_deferred(input state_t s);
    return (s == ST_REQ) || (s == ST_BURST) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cam_frame_writer.sv
// Drains the camera pixel FIFO into the camera's SDRAM bank in fixed bursts
// and flags end of frame to the bank switch.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 256,
  parameter int ADDR_W      = 22,
  parameter int DONE_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic              vsync_sync,
  input  logic [1:0]        cam_bank,
  input  logic [15:0]       fifo_q,
  input  logic [9:0]        fifo_count,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic              fifo_aclr,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data_req,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              underrun,
  output logic              frame_err
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(DONE_HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [10:0]       FILL_LEVEL = 11'(BURST_LEN);

  state_t              state_reg, state_next;
  logic                vsync_d_reg;
  logic [1:0]          wr_bank_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [BCNT_W-1:0]   burst_cnt_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic                pending_reg;
  logic                frame_open_reg;
  logic                underrun_reg;
  logic                fifo_aclr_reg;
  logic                frame_err_reg;

  logic vsync_edge;
  logic word_take;
  logic burst_end;
  logic frame_end;
  logic hold_end;
  logic start_frame;
  logic abort_frame;

  assign vsync_edge = vsync_sync & ~vsync_d_reg;
  assign word_take  = (state_reg == ST_BURST) && wr_data_req;
  assign burst_end  = word_take && (burst_cnt_reg == BURST_LAST);
  // wr_addr is the offset of the burst in flight, so the last burst of a
  // frame is the one starting at FRAME_WORDS-BURST_LEN.
  assign frame_end  = burst_end && (wr_addr_reg == ADDR_LAST);
  assign hold_end   = (state_reg == ST_DONE) && (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    abort_frame = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vsync_edge) begin
          start_frame = 1'b1;
          abort_frame = frame_open_reg;
          state_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (vsync_edge) begin
          start_frame = 1'b1;
          abort_frame = 1'b1;
        end else if ({1'b0, fifo_count} >= FILL_LEVEL) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_ack) state_next = ST_BURST;
      end
      ST_BURST: begin
        if (frame_end) begin
          state_next = ST_DONE;
        end else if (burst_end) begin
          state_next = ST_FILL;
          if (pending_reg || vsync_edge) begin
            start_frame = 1'b1;
            abort_frame = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (hold_end) begin
          if (pending_reg || vsync_edge) begin
            start_frame = 1'b1;
            state_next  = ST_FILL;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_req     = 1'b0;
    fifo_rdreq = 1'b0;
    frame_done = ~FRAME_DONE_ACTIVE;
    case (state_reg)
      ST_REQ:   wr_req = 1'b1;
      ST_BURST: fifo_rdreq = wr_data_req & ~fifo_empty;
      ST_DONE:  frame_done = FRAME_DONE_ACTIVE;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      vsync_d_reg    <= 1'b0;
      wr_bank_reg    <= CAM_RESET_BANK;
      wr_addr_reg    <= '0;
      burst_cnt_reg  <= '0;
      hold_cnt_reg   <= '0;
      pending_reg    <= 1'b0;
      frame_open_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      fifo_aclr_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      vsync_d_reg   <= vsync_sync;
      fifo_aclr_reg <= start_frame;
      frame_err_reg <= abort_frame;

      if (start_frame) begin
        wr_bank_reg   <= cam_bank;
        wr_addr_reg   <= '0;
        burst_cnt_reg <= '0;
      end else if (word_take) begin
        // Counter wraps to zero on its own since BURST_LEN is a power of two.
        burst_cnt_reg <= burst_cnt_reg + 1'b1;
        if (burst_end) wr_addr_reg <= wr_addr_reg + ADDR_STEP;
      end

      if (state_reg == ST_DONE) hold_cnt_reg <= hold_cnt_reg + 1'b1;
      else                      hold_cnt_reg <= '0;

      if (start_frame)
        pending_reg <= 1'b0;
      else if (vsync_edge && vsync_deferred(state_reg))
        pending_reg <= 1'b1;

      if (start_frame)    frame_open_reg <= 1'b1;
      else if (frame_end) frame_open_reg <= 1'b0;

      if (start_frame)                    underrun_reg <= 1'b0;
      else if (word_take && fifo_empty)   underrun_reg <= 1'b1;
    end
  end

  assign wr_bank   = wr_bank_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = fifo_q;
  assign underrun  = underrun_reg;
  assign fifo_aclr = fifo_aclr_reg;
  assign frame_err = frame_err_reg;

endmodule
